// File: rtl/vc_credit_sender_pkg.sv
// Shared types for the credit-based ring link sender.
// Holds the drain FSM encoding and the credit-width helper.
package vc_credit_sender_pkg;

  typedef enum logic [1:0] {
    VC_CREDIT_RUN   = 2'd0,
    VC_CREDIT_DRAIN = 2'd1,
    VC_CREDIT_ACK   = 2'd2,
    VC_CREDIT_WAIT  = 2'd3
  } vc_state_e;

  function automatic int vc_cnt_nbits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Up/down credit counter, saturating at both ends.
// Resets full; ovf flags an increment that would pass the maximum.
module vc_credit_counter #(
  parameter int p_max   = 2,
  parameter int p_nbits = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [p_nbits-1:0] count,
  output logic               ovf
);

  localparam logic [p_nbits-1:0] c_max = p_nbits'(p_max);
  localparam logic [p_nbits-1:0] c_one = p_nbits'(1);

  logic up;
  logic dn;

  always_comb begin
    up  = inc && !dec;
    dn  = dec && !inc;
    ovf = up && (count == c_max);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= c_max;
    end else begin
      unique case (1'b1)
        (up && count != c_max): count <= count + c_one;
        (dn && count != '0):    count <= count - c_one;
        default:                count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_credit_sender.sv
// Transmit end of a credit-flow-controlled ring link with domain drain.
// Optional sticky err output when VC_CREDIT_SENDER_ERR_EN is defined.
module vc_credit_sender
  import vc_credit_sender_pkg::*;
#(
  parameter int p_msg_nbits   = 1,
  parameter int p_num_credits = 2,
  localparam int c_cnt_nbits  = vc_cnt_nbits(p_num_credits)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   domain,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  output logic [p_msg_nbits-1:0] out_msg,
  input  logic                   cred_ret,
  input  logic                   sw_req,
  output logic                   sw_ack,
  output logic [c_cnt_nbits-1:0] num_credits
`ifdef VC_CREDIT_SENDER_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam logic [c_cnt_nbits-1:0] c_full =
    c_cnt_nbits'(p_num_credits);

  vc_state_e state;
  logic      fire;
  logic      ovf;
  logic      unused_domain;

  // domain is a label only; the sender does not act on it
  assign unused_domain = domain;

  assign in_rdy = (state == VC_CREDIT_RUN)
               && (num_credits != '0)
               && !sw_req;
  assign fire   = in_val && in_rdy;

  vc_credit_counter #(
    .p_max   (p_num_credits),
    .p_nbits (c_cnt_nbits)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cred_ret),
    .dec   (fire),
    .count (num_credits),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= VC_CREDIT_RUN;
      out_val <= 1'b0;
      out_msg <= '0;
      sw_ack  <= 1'b0;
    end else begin
      out_val <= fire;
      if (fire) out_msg <= in_msg;
      sw_ack <= 1'b0;
      unique case (state)
        VC_CREDIT_RUN:
          if (sw_req) state <= VC_CREDIT_DRAIN;
        VC_CREDIT_DRAIN:
          if (num_credits == c_full) begin
            state  <= VC_CREDIT_ACK;
            sw_ack <= 1'b1;
          end
        VC_CREDIT_ACK:
          state <= VC_CREDIT_WAIT;
        VC_CREDIT_WAIT:
          if (!sw_req) state <= VC_CREDIT_RUN;
        default:
          state <= VC_CREDIT_RUN;
      endcase
    end
  end

`ifdef VC_CREDIT_SENDER_ERR_EN
  // a return while idle-and-full means the receiver lost count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (ovf
              || (cred_ret && state == VC_CREDIT_WAIT
                  && num_credits == c_full)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  a_no_x : assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({in_val, cred_ret, sw_req}));

endmodule

// File: tb/tb_vc_credit_sender.sv
// Directed plus random bench for vc_credit_sender (8-bit msgs, 2 credits).
module tb_vc_credit_sender;

  localparam int W = 8;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         domain;
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] in_msg;
  logic         out_val;
  logic [W-1:0] out_msg;
  logic         cred_ret;
  logic         sw_req;
  logic         sw_ack;
  logic [1:0]   num_credits;
`ifdef VC_CREDIT_SENDER_ERR_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  vc_credit_sender #(.p_msg_nbits(W), .p_num_credits(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .domain      (domain),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_msg      (in_msg),
    .out_val     (out_val),
    .out_msg     (out_msg),
    .cred_ret    (cred_ret),
    .sw_req      (sw_req),
    .sw_ack      (sw_ack),
    .num_credits (num_credits)
`ifdef VC_CREDIT_SENDER_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] m,
                       input logic r, input logic s);
    in_val   = v;
    in_msg   = m;
    cred_ret = r;
    sw_req   = s;
    #1;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  int           mcred;
  logic [W-1:0] mlast;
  logic         mrdy;
  logic         mfire;
  logic         v;
  logic         r;
  logic [W-1:0] m;

  initial begin
    reset  = 1'b0;
    domain = 1'b0;
    drive(0, '0, 0, 0);
    clk1();
    clk1();
    chk("rst_cred", 32'(num_credits), 2);
    chk("rst_oval", 32'(out_val), 0);
    chk("rst_omsg", 32'(out_msg), 0);
    chk("rst_ack", 32'(sw_ack), 0);

    // burst of three with no returns: only two launch
    reset = 1'b1;
    drive(1, 8'h0A, 0, 0);
    chk("b_rdy0", 32'(in_rdy), 1);
    clk1();
    chk("b_v1", 32'(out_val), 1);
    chk("b_m1", 32'(out_msg), 8'h0A);
    chk("b_c1", 32'(num_credits), 1);
    drive(1, 8'h0B, 0, 0);
    clk1();
    chk("b_v2", 32'(out_val), 1);
    chk("b_m2", 32'(out_msg), 8'h0B);
    chk("b_c2", 32'(num_credits), 0);
    drive(1, 8'h0C, 0, 0);
    chk("b_rdy2", 32'(in_rdy), 0);
    clk1();
    chk("b_v3", 32'(out_val), 0);
    chk("b_hold", 32'(out_msg), 8'h0B);

    // one credit back releases 0xC
    drive(1, 8'h0C, 1, 0);
    clk1();
    drive(1, 8'h0C, 0, 0);
    chk("r_rdy", 32'(in_rdy), 1);
    clk1();
    chk("r_v", 32'(out_val), 1);
    chk("r_m", 32'(out_msg), 8'h0C);
    chk("r_c", 32'(num_credits), 0);

    // simultaneous fire and return at one credit
    drive(0, '0, 1, 0);
    clk1();
    chk("s_c1", 32'(num_credits), 1);
    drive(1, 8'h55, 1, 0);
    clk1();
    chk("s_c", 32'(num_credits), 1);
    chk("s_v", 32'(out_val), 1);
    chk("s_m", 32'(out_msg), 8'h55);
    drive(1, 8'h66, 0, 0);
    clk1();
    chk("s_c0", 32'(num_credits), 0);

    // domain switch drain with two spaced returns
    drive(1, 8'h77, 0, 1);
    chk("d_rdy0", 32'(in_rdy), 0);
    clk1();
    drive(1, 8'h77, 1, 1);
    chk("d_rdy1", 32'(in_rdy), 0);
    clk1();
    for (int i = 0; i < 2; i++) begin
      drive(1, 8'h77, 0, 1);
      chk("d_rdyw", 32'(in_rdy), 0);
      chk("d_ackw", 32'(sw_ack), 0);
      clk1();
    end
    drive(1, 8'h77, 1, 1);
    clk1();
    chk("d_full", 32'(num_credits), 2);
    chk("d_ack0", 32'(sw_ack), 0);
    drive(1, 8'h77, 0, 1);
    chk("d_rdy2", 32'(in_rdy), 0);
    clk1();
    chk("d_ack1", 32'(sw_ack), 1);
    chk("d_noval", 32'(out_val), 0);
    clk1();
    chk("d_ack2", 32'(sw_ack), 0);
    drive(0, '0, 0, 0);
    chk("d_rdyw2", 32'(in_rdy), 0);
    clk1();
    chk("d_run", 32'(in_rdy), 1);

    // async reset mid-burst
    drive(1, 8'h99, 0, 0);
    clk1();
    chk("a_v", 32'(out_val), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("a_v0", 32'(out_val), 0);
    chk("a_c", 32'(num_credits), 2);
    chk("a_m", 32'(out_msg), 0);
    drive(0, '0, 0, 0);
    clk1();
    reset = 1'b1;

    // random traffic against a credit-ledger model
    mcred = N;
    mlast = '0;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      m = W'($urandom);
      r = (mcred < N) && ($urandom_range(0, 2) == 0);
      mrdy = (mcred > 0);
      drive(v, m, r, 0);
      chk("x_rdy", 32'(in_rdy), 32'(mrdy));
      mfire = v && mrdy;
      clk1();
      mcred = mcred - int'(mfire) + int'(r);
      if (mfire) mlast = m;
      chk("x_cred", 32'(num_credits), 32'(mcred));
      chk("x_val", 32'(out_val), 32'(mfire));
      chk("x_msg", 32'(out_msg), 32'(mlast));
    end

`ifdef VC_CREDIT_SENDER_ERR_EN
    drive(0, '0, 0, 0);
    for (int i = 0; i < N; i++) begin
      drive(0, '0, (mcred < N), 0);
      clk1();
      if (mcred < N) mcred++;
    end
    chk("e_pre", 32'(err), 0);
    drive(0, '0, 1, 0);
    clk1();
    chk("e_set", 32'(err), 1);
    chk("e_cred", 32'(num_credits), 2);
    drive(0, '0, 0, 0);
    clk1();
    clk1();
    chk("e_stick", 32'(err), 1);
    reset = 1'b0;
    #1;
    chk("e_clr", 32'(err), 0);
    reset = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
